// File: rtl/alu_sequencer_pkg.sv
// Shared opcodes, FSM encoding and default widths for the ALU sequencer.
// The opcode map follows the downstream ALU, except that 111 means LDI.
package alu_sequencer_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int REG_AW_DEF = 2;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_NOTA = 3'b101;
   localparam logic [2:0] OP_NOTB = 3'b110;
   localparam logic [2:0] OP_LDI  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   function automatic logic op_writes_reg(input logic [2:0] op);
      return op != OP_NOP;
   endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// Register file for the sequencer: two async read ports, an async debug port,
// one synchronous write port, cleared by the asynchronous active-low reset.
module seq_regfile #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [REG_AW-1:0] i_ra_addr,
   output logic [DATA_W-1:0] o_ra_data,
   input  logic [REG_AW-1:0] i_rb_addr,
   output logic [DATA_W-1:0] o_rb_data,
   input  logic [REG_AW-1:0] i_dbg_addr,
   output logic [DATA_W-1:0] o_dbg_data
);

   localparam int DEPTH = 1 << REG_AW;

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Reads see the pre-write contents during the write cycle.
   assign o_ra_data  = r_mem[i_ra_addr];
   assign o_rb_data  = r_mem[i_rb_addr];
   assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state control stage feeding an external combinational ALU: accept an
// instruction, read operands, capture the result, write back and report it.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        instr_op,
   input  logic [REG_AW-1:0] instr_rd,
   input  logic [REG_AW-1:0] instr_rs1,
   input  logic [REG_AW-1:0] instr_rs2,
   input  logic [DATA_W-1:0] instr_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_opcode,
   input  logic [DATA_W-1:0] alu_result,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_data,
   output logic [REG_AW-1:0] res_rd,
   output logic              res_zero,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [1:0]        dbg_state
);

   // Handshake: an instruction transfers on a rising edge where instr_valid
   // and instr_ready are both high; instr_ready is high only in IDLE, and
   // instr_* is ignored at every other time.

   state_t            r_state;
   logic [2:0]        r_op;
   logic [REG_AW-1:0] r_rd;
   logic [REG_AW-1:0] r_rs1;
   logic [REG_AW-1:0] r_rs2;
   logic [DATA_W-1:0] r_imm;
   logic [DATA_W-1:0] r_result;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [2:0]        r_alu_opcode;
   logic              r_res_valid;
   logic [DATA_W-1:0] r_res_data;
   logic [REG_AW-1:0] r_res_rd;
   logic              r_res_zero;

   logic              w_accept;
   logic              w_we;
   logic [DATA_W-1:0] w_rdata_a;
   logic [DATA_W-1:0] w_rdata_b;
   logic [DATA_W-1:0] w_result;

   assign instr_ready = rst_n && (r_state == ST_IDLE);
   assign w_accept    = instr_valid && instr_ready;
   assign w_we        = (r_state == ST_WB) && op_writes_reg(r_op);

   // LDI bypasses the ALU; NOP always retires zero regardless of the ALU.
   assign w_result = (r_op == OP_LDI) ? r_imm :
                     (r_op == OP_NOP) ? '0    : alu_result;

   seq_regfile #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_we       (w_we),
      .i_waddr    (r_rd),
      .i_wdata    (r_result),
      .i_ra_addr  (r_rs1),
      .o_ra_data  (w_rdata_a),
      .i_rb_addr  (r_rs2),
      .o_rb_data  (w_rdata_b),
      .i_dbg_addr (dbg_addr),
      .o_dbg_data (dbg_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_op         <= '0;
         r_rd         <= '0;
         r_rs1        <= '0;
         r_rs2        <= '0;
         r_imm        <= '0;
         r_result     <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_opcode <= '0;
         r_res_valid  <= 1'b0;
         r_res_data   <= '0;
         r_res_rd     <= '0;
         r_res_zero   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op    <= instr_op;
                  r_rd    <= instr_rd;
                  r_rs1   <= instr_rs1;
                  r_rs2   <= instr_rs2;
                  r_imm   <= instr_imm;
                  r_state <= ST_READ;
               end
            end
            ST_READ: begin
               // LDI drives 111, which the ALU treats as zero.
               r_alu_a      <= w_rdata_a;
               r_alu_b      <= w_rdata_b;
               r_alu_opcode <= r_op;
               r_state      <= ST_EXEC;
            end
            ST_EXEC: begin
               r_result    <= w_result;
               r_res_valid <= 1'b1;
               r_res_data  <= w_result;
               r_res_rd    <= r_rd;
               r_res_zero  <= (w_result == '0);
               r_state     <= ST_WB;
            end
            ST_WB: begin
               r_res_valid <= 1'b0;
               r_res_zero  <= 1'b0;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_opcode = r_alu_opcode;
   assign res_valid  = r_res_valid;
   assign res_data   = r_res_data;
   assign res_rd     = r_res_rd;
   assign res_zero   = r_res_zero;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural ALU alongside it; a register
// model predicts each retirement and a monitor checks it on res_valid.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [2:0] instr_op = '0;
   logic [1:0] instr_rd = '0;
   logic [1:0] instr_rs1 = '0;
   logic [1:0] instr_rs2 = '0;
   logic [7:0] instr_imm = '0;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [2:0] alu_opcode;
   logic [7:0] alu_result;
   logic       res_valid;
   logic [7:0] res_data;
   logic [1:0] res_rd;
   logic       res_zero;
   logic [1:0] dbg_addr = '0;
   logic [7:0] dbg_data;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int retired = 0;

   logic [7:0] m_reg [4];
   logic [7:0] exp_q[$];
   logic [1:0] exp_rd_q[$];
   int         exp_cyc_q[$];

   alu_sequencer #(.DATA_W(8), .REG_AW(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_op    (instr_op),
      .instr_rd    (instr_rd),
      .instr_rs1   (instr_rs1),
      .instr_rs2   (instr_rs2),
      .instr_imm   (instr_imm),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_opcode  (alu_opcode),
      .alu_result  (alu_result),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .res_rd      (res_rd),
      .res_zero    (res_zero),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset / ALU ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      alu_result = 8'h00;
      case (alu_opcode)
         3'b001: alu_result = alu_a + alu_b;
         3'b010: alu_result = alu_a - alu_b;
         3'b011: alu_result = alu_a & alu_b;
         3'b100: alu_result = alu_a | alu_b;
         3'b101: alu_result = ~alu_a;
         3'b110: alu_result = ~alu_b;
         default: alu_result = 8'h00;
      endcase
   end

   initial begin
      #300000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n && res_valid === 1'b1) begin
         retired++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_retire got data=%h rd=%0d, required no retire", res_data, res_rd);
         end else begin
            logic [7:0] e;
            logic [1:0] erd;
            int         ec;
            e   = exp_q.pop_front();
            erd = exp_rd_q.pop_front();
            ec  = exp_cyc_q.pop_front();
            if (res_data !== e) begin
               errors++;
               $display("FAIL res_data got %h required %h", res_data, e);
            end
            checks++;
            if (res_rd !== erd) begin
               errors++;
               $display("FAIL res_rd got %0d required %0d", res_rd, erd);
            end
            checks++;
            if (res_zero !== (e == 8'h00)) begin
               errors++;
               $display("FAIL res_zero got %b required %b", res_zero, (e == 8'h00));
            end
            checks++;
            if (cyc != ec) begin
               errors++;
               $display("FAIL res_latency got cycle %0d required %0d", cyc, ec);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [7:0] imm, input bit hold,
                       output int waits);
      logic [7:0] a, b, e;
      waits = 0;
      instr_valid = 1'b1;
      instr_op  = op;
      instr_rd  = rd;
      instr_rs1 = rs1;
      instr_rs2 = rs2;
      instr_imm = imm;
      while (instr_ready !== 1'b1 && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (instr_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout got ready=%b required 1 within 20 cycles", instr_ready);
         instr_valid = 1'b0;
         return;
      end
      a = m_reg[rs1];
      b = m_reg[rs2];
      case (op)
         3'b001:  e = a + b;
         3'b010:  e = a - b;
         3'b011:  e = a & b;
         3'b100:  e = a | b;
         3'b101:  e = ~a;
         3'b110:  e = ~b;
         3'b111:  e = imm;
         default: e = 8'h00;
      endcase
      exp_q.push_back(e);
      exp_rd_q.push_back(rd);
      exp_cyc_q.push_back(cyc + 3);
      if (op != 3'b000) m_reg[rd] = e;
      @(posedge clk);
      @(negedge clk);
      if (!hold) instr_valid = 1'b0;
   endtask

   task automatic drain;
      int t = 0;
      while (exp_q.size() != 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending required 0", exp_q.size());
         exp_q.delete();
         exp_rd_q.delete();
         exp_cyc_q.delete();
      end
   endtask

   task automatic check_reg(input logic [1:0] r, input logic [7:0] v, input string name);
      dbg_addr = r;
      #1;
      checks++;
      if (dbg_data !== v) begin
         errors++;
         $display("FAIL %s got %h required %h", name, dbg_data, v);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({alu_a, alu_b, alu_opcode, res_valid, res_data, res_rd, res_zero, instr_ready, dbg_state} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got a=%h b=%h op=%h v=%b d=%h rd=%h z=%b rdy=%b st=%h required all 0",
                  alu_a, alu_b, alu_opcode, res_valid, res_data, res_rd, res_zero, instr_ready, dbg_state);
      end
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b required 1", instr_ready);
      end
      for (int i = 0; i < 4; i++) check_reg(2'(i), 8'h00, "reset_regfile");
   endtask

   task automatic test_ldi_add;
      int w;
      send(3'b111, 2'd1, 2'd0, 2'd0, 8'h05, 1'b0, w);
      send(3'b111, 2'd2, 2'd0, 2'd0, 8'h03, 1'b0, w);
      send(3'b001, 2'd3, 2'd1, 2'd2, 8'h00, 1'b0, w);
      drain();
      check_reg(2'd3, 8'h08, "add_r3");
   endtask

   task automatic test_sub_nota;
      int w;
      send(3'b010, 2'd0, 2'd2, 2'd1, 8'h00, 1'b0, w);
      drain();
      check_reg(2'd0, 8'hFE, "sub_wrap_r0");
      send(3'b101, 2'd0, 2'd1, 2'd1, 8'h00, 1'b0, w);
      drain();
      check_reg(2'd0, 8'hFA, "nota_r0");
   endtask

   task automatic test_dbg_timing;
      int w, t;
      logic [7:0] old_v;
      old_v = m_reg[0];
      dbg_addr = 2'd0;
      send(3'b111, 2'd0, 2'd0, 2'd0, 8'h5A, 1'b0, w);
      t = 0;
      while (res_valid !== 1'b1 && t < 10) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (dbg_data !== old_v) begin
         errors++;
         $display("FAIL dbg_during_wb got %h required %h", dbg_data, old_v);
      end
      @(negedge clk);
      checks++;
      if (dbg_data !== 8'h5A) begin
         errors++;
         $display("FAIL dbg_after_wb got %h required 5a", dbg_data);
      end
      drain();
   endtask

   task automatic test_back_to_back;
      int w;
      int base;
      base = retired;
      for (int i = 0; i < 8; i++) begin
         send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b1, w);
         if (i > 0) begin
            checks++;
            if (w != 3) begin
               errors++;
               $display("FAIL ready_pattern got %0d low cycles required 3", w);
            end
         end
      end
      instr_valid = 1'b0;
      drain();
      checks++;
      if (retired - base != 8) begin
         errors++;
         $display("FAIL b2b_count got %0d retired required 8", retired - base);
      end
      for (int i = 0; i < 4; i++) check_reg(2'(i), m_reg[i], "b2b_regfile");
   endtask

   task automatic test_nop_and;
      int w;
      send(3'b111, 2'd1, 2'd0, 2'd0, 8'h05, 1'b0, w);
      send(3'b111, 2'd2, 2'd0, 2'd0, 8'h02, 1'b0, w);
      send(3'b000, 2'd1, 2'd2, 2'd2, 8'hFF, 1'b0, w);
      drain();
      check_reg(2'd1, 8'h05, "nop_keeps_r1");
      send(3'b011, 2'd0, 2'd1, 2'd2, 8'h00, 1'b0, w);
      drain();
      check_reg(2'd0, 8'h00, "and_r0");
   endtask

   task automatic test_reset_mid;
      int w;
      send(3'b111, 2'd3, 2'd0, 2'd0, 8'h77, 1'b0, w);
      drain();
      send(3'b001, 2'd3, 2'd1, 2'd2, 8'h00, 1'b0, w);
      @(negedge clk);
      checks++;
      if (dbg_state !== 2'd2) begin
         errors++;
         $display("FAIL mid_state got %0d required 2 (EXEC)", dbg_state);
      end
      rst_n = 1'b0;
      exp_q.delete();
      exp_rd_q.delete();
      exp_cyc_q.delete();
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check_reg(2'd3, 8'h00, "mid_reset_r3");
      checks++;
      if (instr_ready !== 1'b1 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL mid_reset_idle got ready=%b state=%0d required ready=1 state=0", instr_ready, dbg_state);
      end
   endtask

   initial begin
      test_reset();
      test_ldi_add();
      test_sub_nota();
      test_dbg_timing();
      test_back_to_back();
      test_nop_and();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control stage directly upstream of the 8-bit combinational ALU (3-bit opcode: 000 zero, 001 add, 010 sub, 011 and, 100 or, 101 not-A, 110 not-B, 111 zero).
- Accepts instructions over a valid/ready handshake and reads two operands from an internal register file.
- Drives the ALU's operand and opcode inputs from registers, captures the ALU result, writes it back to the destination register and reports it on a result port.
- Multi-cycle FSM; one instruction in flight.

Parameters:
- DATA_W, 8, datapath and register width; must match the ALU operand width.
- REG_AW, 2, register-file address width; the file holds 2**REG_AW registers.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept (high only in IDLE).
- instr_op  in  3  opcode; 111 is redefined here as LDI.
- instr_rd  in  REG_AW  destination register.
- instr_rs1  in  REG_AW  source A register.
- instr_rs2  in  REG_AW  source B register.
- instr_imm  in  DATA_W  immediate, used only by LDI.
- alu_a  out  DATA_W  ALU operand 1, registered.
- alu_b  out  DATA_W  ALU operand 2, registered.
- alu_opcode  out  3  ALU opcode, registered.
- alu_result  in  DATA_W  ALU output, combinational from alu_a/alu_b/alu_opcode.
- res_valid  out  1  one-cycle pulse when an instruction retires.
- res_data  out  DATA_W  retired value.
- res_rd  out  REG_AW  destination of the retired instruction.
- res_zero  out  1  res_data == 0, qualified by res_valid.
- dbg_addr  in  REG_AW  debug read address.
- dbg_data  out  DATA_W  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; all registers cleared to 0.
  - alu_a, alu_b, alu_opcode, res_valid, res_data, res_rd and res_zero all 0.
  - instr_ready is 1 once rst_n deasserts.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE. Transitions are unconditional except the exit from IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready: latch op/rd/rs1/rs2/imm and go to READ.
  - Otherwise stay in IDLE.
- READ:
  - alu_a <= reg[rs1], alu_b <= reg[rs2], alu_opcode <= op.
  - For LDI, alu_opcode <= 111 (ALU outputs 0 and the value is ignored).
- EXEC: capture result_q <= (op==111) ? imm : alu_result.
- WB:
  - If op!=000, reg[rd] <= result_q at the end of the cycle.
  - res_valid=1, res_data=result_q, res_rd=rd, res_zero=(result_q==0) for exactly this cycle.
  - op 000 (NOP) retires with res_data=0 and res_zero=1 but no register write.
- Latency and throughput:
  - Handshake at edge N gives res_valid high in cycle N+3.
  - res_valid deasserts at N+4, when the sequencer is back in IDLE.
  - Throughput is 1 instruction per 4 cycles.
- Handshake rules:
  - instr_ready=0 in READ/EXEC/WB; instr_* is ignored there.
  - A producer holding instr_valid high is accepted on the first IDLE cycle.
- Arithmetic: wrap-around modulo 2**DATA_W is done by the ALU; the sequencer applies no saturation or flags beyond res_zero.
- Hazards:
  - rs1/rs2 equal to the previous rd read the written-back value, because WB completes before the next READ.
  - rs1==rs2 is legal.
  - rd==rs1 is legal; the write occurs after the read.
- dbg_data is combinational. Reading the WB target during WB returns the old value; the new value appears from the next cycle.
- Reset mid-operation: the in-flight instruction is dropped, no res_valid pulse, registers cleared.
- alu_* outputs hold their values outside READ; they are not cleared between instructions.

Decomposition:
- Shared package holds:
  - Opcode localparams OP_NOP=000, OP_ADD=001, OP_SUB=010, OP_AND=011, OP_OR=100, OP_NOTA=101, OP_NOTB=110, OP_LDI=111.
  - FSM state encodings.
  - DATA_W default.
- One natural sub-module: seq_regfile (2**REG_AW x DATA_W, two async read ports plus a debug read port, one sync write port, async active-low clear).
- The FSM and ALU interface registers stay in alu_sequencer.
- The ALU itself is instantiated alongside the sequencer in the enclosing top, not inside it.

Test Plan:
- Reset: rst_n=0 mid-cycle with no clock edge -> all outputs 0 immediately. After release, instr_ready=1 and dbg_data=0 for every address.
- LDI r1,0x05 then LDI r2,0x03 then ADD r3=r1+r2:
  - res_valid high 3 cycles after each accept.
  - res_data 0x05, 0x03, 0x08 with res_rd 1, 2, 3.
  - dbg_addr=3 gives 0x08.
- SUB r0=r2-r1 with r1=0x05, r2=0x03 -> res_data=0xFE (wrap), res_zero=0. NOTA r0=~r1 -> 0xFA.
- Backpressure: instr_valid held high continuously with a new instruction presented immediately after each accept:
  - instr_ready pattern is 1,0,0,0 repeating.
  - Each instruction is accepted exactly once.
  - No instruction is lost or duplicated.
- NOP with rd=1 (r1=0x05) -> res_valid pulse, res_data=0, res_zero=1, r1 still 0x05. AND r0=r1&r2 (0x05&0x02) -> 0x00, res_zero=1.
- Assert rst_n=0 during EXEC of ADD r3 -> no res_valid pulse, r3=0, FSM in IDLE, instr_ready=1 after release.
